instruction_fetch_unit: RTL and testbench

Front-end stage of the RISC-V CPU. It owns the program counter and issues word requests to instruction memory, which may take a variable number of cycles to answer. Each returned instruction goes into an IF output register that directly feeds the control decoder and register file. The block also handles downstream stalls with a one-entry skid buffer, and redirects from branch/JAL/JALR resolution, including squashing a memory response that is already in flight.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/if_skid_buffer.sv | 49 ++++
 rtl/instruction_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V front end: reset PC, NOP encoding,
// fetch FSM state encoding and the packed fetch-entry type.
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SKID = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// Single-entry holding register that catches a fetched instruction while
// the IF output register is occupied and stalled.
module if_skid_buffer
    import riscv_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  fetch_entry_t entry_i,
    input  logic         drain_i,
    input  logic         flush_i,
    output logic         valid_o,
    output fetch_entry_t entry_o
);

    logic         validQ;
    logic         validD;
    fetch_entry_t entryQ;
    fetch_entry_t entryD;

    // Flush beats load beats drain, so a redirect always empties the entry.
    always_comb begin
        validD = validQ;
        entryD = entryQ;
        if (flush_i) begin
            validD = 1'b0;
        end else if (load_i) begin
            validD = 1'b1;
            entryD = entry_i;
        end else if (drain_i) begin
            validD = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            validQ       <= 1'b0;
            entryQ.instr <= NOP_INSTR;
            entryQ.pc    <= RESET_PC_DEFAULT;
        end else begin
            validQ <= validD;
            entryQ <= entryD;
        end
    end

    assign valid_o = validQ;
    assign entry_o = entryQ;

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, issues one outstanding word request at a time,
// buffers through a one-entry skid and squashes responses made stale by redirects.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        iCLK,
    input  logic        iRST,
    output logic        oIMemReq,
    output logic [31:0] oIMemAddr,
    input  logic        iIMemReady,
    input  logic [31:0] iIMemData,
    input  logic        iStall,
    input  logic        iRedirect,
    input  logic [31:0] iRedirectPC,
    output logic        oValid,
    output logic [31:0] oInstruction,
    output logic [31:0] oPC,
    output logic [31:0] oPCPlus4
);

    import riscv_pkg::*;

    fetch_state_e stateQ;
    fetch_state_e stateD;
    logic [31:0]  pcQ;
    logic [31:0]  pcD;
    logic [31:0]  reqAddrQ;
    logic [31:0]  reqAddrD;
    logic         discardQ;
    logic         discardD;
    logic         reqQ;
    logic         outValidQ;
    logic         outValidD;
    fetch_entry_t outEntryQ;
    fetch_entry_t outEntryD;

    fetch_entry_t fetchedEntry;
    fetch_entry_t skidEntry;
    logic         skidValid;
    logic         skidLoad;
    logic         skidDrain;
    logic         skidFlush;
    logic         outFree;
    logic [31:0]  redirectTarget;

    assign fetchedEntry   = {iIMemData, reqAddrQ};
    assign redirectTarget = iRedirectPC & ~32'h3;
    assign outFree        = !outValidQ || !iStall;

    if_skid_buffer uSkid (
        .clk_i   (iCLK),
        .rst_i   (iRST),
        .load_i  (skidLoad),
        .entry_i (fetchedEntry),
        .drain_i (skidDrain),
        .flush_i (skidFlush),
        .valid_o (skidValid),
        .entry_o (skidEntry)
    );

    // A redirect in S_REQ leaves the request at its old address; the
    // pending answer is then thrown away via discardQ.
    always_comb begin
        stateD    = stateQ;
        pcD       = pcQ;
        reqAddrD  = reqAddrQ;
        discardD  = discardQ;
        outValidD = outValidQ && iStall;
        outEntryD = outEntryQ;
        skidLoad  = 1'b0;
        skidDrain = 1'b0;
        skidFlush = 1'b0;

        if (iRedirect) begin
            outValidD = 1'b0;
            skidFlush = 1'b1;
            pcD       = redirectTarget;
            stateD    = S_REQ;
            if (stateQ != S_REQ || iIMemReady) begin
                reqAddrD = redirectTarget;
                discardD = 1'b0;
            end else begin
                discardD = 1'b1;
            end
        end else begin
            case (stateQ)
                S_IDLE: begin
                    stateD   = S_REQ;
                    reqAddrD = pcQ;
                end
                S_REQ: begin
                    if (iIMemReady) begin
                        if (discardQ) begin
                            discardD = 1'b0;
                            reqAddrD = pcQ;
                        end else if (outFree) begin
                            outValidD = 1'b1;
                            outEntryD = fetchedEntry;
                            pcD       = pcPlus4(reqAddrQ);
                            reqAddrD  = pcPlus4(reqAddrQ);
                        end else begin
                            skidLoad = 1'b1;
                            pcD      = pcPlus4(reqAddrQ);
                            stateD   = S_SKID;
                        end
                    end
                end
                S_SKID: begin
                    if (!iStall && skidValid) begin
                        outValidD = 1'b1;
                        outEntryD = skidEntry;
                        skidDrain = 1'b1;
                        stateD    = S_REQ;
                        reqAddrD  = pcQ;
                    end
                end
                default: begin
                    stateD = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            stateQ          <= S_IDLE;
            pcQ             <= RESET_PC;
            reqAddrQ        <= RESET_PC;
            discardQ        <= 1'b0;
            reqQ            <= 1'b0;
            outValidQ       <= 1'b0;
            outEntryQ.instr <= NOP_INSTR;
            outEntryQ.pc    <= RESET_PC;
        end else begin
            stateQ    <= stateD;
            pcQ       <= pcD;
            reqAddrQ  <= reqAddrD;
            discardQ  <= discardD;
            reqQ      <= (stateD == S_REQ);
            outValidQ <= outValidD;
            outEntryQ <= outEntryD;
        end
    end

    assign oIMemReq     = reqQ;
    assign oIMemAddr    = reqAddrQ;
    assign oValid       = outValidQ;
    assign oInstruction = outValidQ ? outEntryQ.instr : NOP_INSTR;
    assign oPC          = outEntryQ.pc;
    assign oPCPlus4     = pcPlus4(outEntryQ.pc);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: variable-latency memory model
// plus a scoreboard of expected PCs popped whenever decode consumes an instruction.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iIMemReady = 1'b0;
    logic [31:0] iIMemData = 32'h0;
    logic        iStall = 1'b0;
    logic        iRedirect = 1'b0;
    logic [31:0] iRedirectPC = 32'h0;
    logic        oIMemReq;
    logic [31:0] oIMemAddr;
    logic        oValid;
    logic [31:0] oInstruction;
    logic [31:0] oPC;
    logic [31:0] oPCPlus4;

    int          checks = 0;
    int          errors = 0;
    int          memLatency = 1;
    int          memCount = 0;
    logic [31:0] expPc[$];
    logic [31:0] sbPc;
    logic        found;

    instruction_fetch_unit dut (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .oIMemReq     (oIMemReq),
        .oIMemAddr    (oIMemAddr),
        .iIMemReady   (iIMemReady),
        .iIMemData    (iIMemData),
        .iStall       (iStall),
        .iRedirect    (iRedirect),
        .iRedirectPC  (iRedirectPC),
        .oValid       (oValid),
        .oInstruction (oInstruction),
        .oPC          (oPC),
        .oPCPlus4     (oPCPlus4)
    );

    always #5 iCLK = ~iCLK;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic stall, input logic redir,
                                 input logic [31:0] rpc);
        iRST        = rst;
        iStall      = stall;
        iRedirect   = redir;
        iRedirectPC = rpc;
    endtask

    task automatic tick;
        @(posedge iCLK);
        #1;
    endtask

    task automatic pushStream(input logic [31:0] start);
        expPc.delete();
        for (int i = 0; i < 64; i++) expPc.push_back(start + 32'(4 * i));
    endtask

    task automatic resetDut(input int lat);
        memLatency = lat;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick;
        tick;
        expPc.delete();
    endtask

    task automatic checkResetValues(input string pfx);
        checkOutput({pfx, "Valid"}, 32'(oValid), 32'd0);
        checkOutput({pfx, "Req"}, 32'(oIMemReq), 32'd0);
        checkOutput({pfx, "Instr"}, oInstruction, NOP);
        checkOutput({pfx, "Pc"}, oPC, RESET_PC);
        checkOutput({pfx, "Pc4"}, oPCPlus4, RESET_PC + 32'd4);
        checkOutput({pfx, "Addr"}, oIMemAddr, RESET_PC);
    endtask

    // Memory answers on the memLatency-th cycle of each request.
    always @(negedge iCLK) begin
        if (iIMemReady) memCount = 0;
        if (iRST || !oIMemReq) begin
            memCount   = 0;
            iIMemReady = 1'b0;
        end else begin
            memCount++;
            iIMemReady = (memCount >= memLatency);
        end
        iIMemData = iIMemReady ? memWord(oIMemAddr) : 32'hDEAD_BEEF;
    end

    always @(negedge iCLK) begin
        if (!iRST && !iRedirect && oValid && !iStall) begin
            if (expPc.size() == 0) begin
                checkOutput("sbUnderflow", 32'd1, 32'd0);
            end else begin
                sbPc = expPc.pop_front();
                checkOutput("sbPc", oPC, sbPc);
                checkOutput("sbInstr", oInstruction, memWord(sbPc));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // zero-wait streaming from reset
        resetDut(1);
        checkResetValues("rst");
        pushStream(RESET_PC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("idleNoReq", 32'(oIMemReq), 32'd0);
        tick;
        checkOutput("firstReq", 32'(oIMemReq), 32'd1);
        checkOutput("firstReqAddr", oIMemAddr, RESET_PC);
        checkOutput("c1Valid", 32'(oValid), 32'd0);
        tick;
        checkOutput("c2Valid", 32'(oValid), 32'd1);
        checkOutput("c2Pc", oPC, 32'h0040_0000);
        tick;
        checkOutput("c3Pc", oPC, 32'h0040_0004);
        tick;
        checkOutput("c4Pc", oPC, 32'h0040_0008);
        checkOutput("c4Instr", oInstruction, memWord(32'h0040_0008));

        // three-cycle memory latency
        resetDut(3);
        pushStream(RESET_PC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        for (int c = 1; c <= 12; c++) begin
            tick;
            checkOutput("lat3Valid", 32'(oValid), {31'd0, (c % 3 == 1) && (c >= 4)});
            checkOutput("lat3Addr", oIMemAddr, RESET_PC + 32'(4 * ((c - 1) / 3)));
        end

        // four-cycle stall fills the skid entry
        resetDut(1);
        pushStream(RESET_PC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick;
        tick;
        tick;
        checkOutput("stallPreHold", oPC, 32'h0040_0004);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick;
            checkOutput("stallHoldPc", oPC, 32'h0040_0004);
            checkOutput("stallHoldValid", 32'(oValid), 32'd1);
            checkOutput("stallNoReq", 32'(oIMemReq), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick;
        checkOutput("skidDrainPc", oPC, 32'h0040_0008);
        checkOutput("skidDrainReq", 32'(oIMemReq), 32'd1);
        checkOutput("skidDrainAddr", oIMemAddr, 32'h0040_000C);
        tick;
        checkOutput("afterSkidPc", oPC, 32'h0040_000C);

        // redirect while a slow request is in flight
        resetDut(3);
        pushStream(RESET_PC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) tick;
        checkOutput("rdPreValid", 32'(oValid), 32'd1);
        checkOutput("rdPreAddr", oIMemAddr, 32'h0040_0004);
        tick;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0040_0100);
        pushStream(32'h0040_0100);
        tick;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rdOldAddrHeld", oIMemAddr, 32'h0040_0004);
        checkOutput("rdOldReqHeld", 32'(oIMemReq), 32'd1);
        checkOutput("rdValid0", 32'(oValid), 32'd0);
        tick;
        checkOutput("rdNewAddr", oIMemAddr, 32'h0040_0100);
        for (int i = 0; i < 3; i++) begin
            checkOutput("rdWaitValid", 32'(oValid), 32'd0);
            tick;
        end
        checkOutput("rdArriveValid", 32'(oValid), 32'd1);
        checkOutput("rdArrivePc", oPC, 32'h0040_0100);
        checkOutput("rdArriveInstr", oInstruction, memWord(32'h0040_0100));

        // redirect to a misaligned target while parked in the skid state
        resetDut(1);
        pushStream(RESET_PC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick;
        tick;
        tick;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        tick;
        checkOutput("skRdParked", 32'(oIMemReq), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0040_0103);
        pushStream(32'h0040_0100);
        tick;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("skRdValid", 32'(oValid), 32'd0);
        checkOutput("skRdReq", 32'(oIMemReq), 32'd1);
        checkOutput("skRdAddr", oIMemAddr, 32'h0040_0100);
        tick;
        checkOutput("skRdPc", oPC, 32'h0040_0100);
        tick;
        checkOutput("skRdNextPc", oPC, 32'h0040_0104);

        // reset in the middle of an outstanding request
        resetDut(3);
        pushStream(RESET_PC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick;
            if (oIMemReq && oIMemAddr == 32'h0040_0020) found = 1'b1;
        end
        checkOutput("reachPc20", 32'(found), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        expPc.delete();
        tick;
        checkResetValues("midRst");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        pushStream(RESET_PC);
        tick;
        checkOutput("restartReq", 32'(oIMemReq), 32'd1);
        checkOutput("restartAddr", oIMemAddr, RESET_PC);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick;
            if (oValid) found = 1'b1;
        end
        checkOutput("restartValid", 32'(found), 32'd1);
        checkOutput("restartPc", oPC, RESET_PC);

        // redirect coinciding with a response, to the top of the address space
        resetDut(1);
        pushStream(RESET_PC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick;
        tick;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        pushStream(32'hFFFF_FFFC);
        tick;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("wrapValid0", 32'(oValid), 32'd0);
        checkOutput("wrapReq", 32'(oIMemReq), 32'd1);
        checkOutput("wrapAddr", oIMemAddr, 32'hFFFF_FFFC);
        tick;
        checkOutput("wrapPc", oPC, 32'hFFFF_FFFC);
        checkOutput("wrapPc4", oPCPlus4, 32'h0000_0000);
        tick;
        checkOutput("wrapNextPc", oPC, 32'h0000_0000);
        checkOutput("wrapNextPc4", oPCPlus4, 32'h0000_0004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
